// File: rtl/output_interface.sv
// Byte serializer feeding a UART transmitter. It sends either one scalar result
// (3 bytes) or an N_ELEM-element vector read from BRAM (2 bytes each), LSB first.
module output_interface #(
  parameter int N_ELEM = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter int RES_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [RES_W-1:0]  scalar_in,
  output logic [ADDR_W-1:0] bram_rd_addr,
  input  logic [DATA_W-1:0] bram_rd_dout,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    HOLD    = 3'd4,
    WAIT_TX = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEM - 1);

  state_t            state_r, state_s;
  logic [23:0]       shift_r, shift_s;
  logic [1:0]        cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              scalar_mode_r, scalar_mode_s;
  logic [7:0]        tx_data_r, tx_data_s;
  logic              tx_start_r, busy_r, done_r;

  // Next-state, datapath and next-output decode; outputs are registered from these.
  always_comb begin
    state_s       = state_r;
    shift_s       = shift_r;
    cnt_s         = cnt_r;
    addr_s        = addr_r;
    scalar_mode_s = scalar_mode_r;
    tx_data_s     = tx_data_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          scalar_mode_s = mode;
          if (mode) begin
            shift_s = 24'(scalar_in);
            cnt_s   = 2'd3;
            state_s = SEND;
          end else begin
            addr_s  = {ADDR_W{1'b0}};
            state_s = FETCH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: state_s = LATCH;
      LATCH: begin
        shift_s = 24'(bram_rd_dout);
        cnt_s   = 2'd2;
        state_s = SEND;
      end
      SEND: state_s = HOLD;
      // The UART may not have raised tx_busy yet, so this cycle never looks at it.
      HOLD: begin
        shift_s = {8'd0, shift_r[23:8]};
        cnt_s   = cnt_r - 2'd1;
        state_s = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_busy) begin
          state_s = WAIT_TX;
        end else if (cnt_r != 2'd0) begin
          state_s = SEND;
        end else if (!scalar_mode_r && (addr_r < LAST_IDX)) begin
          addr_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_s = FETCH;
        end else begin
          state_s = DONE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    // tx_data is loaded on entry to SEND so it lines up with the tx_start pulse.
    if (state_s == SEND) begin
      tx_data_s = shift_s[7:0];
    end else begin
      tx_data_s = tx_data_r;
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      shift_r       <= 24'd0;
      cnt_r         <= 2'd0;
      addr_r        <= {ADDR_W{1'b0}};
      scalar_mode_r <= 1'b0;
      tx_data_r     <= 8'd0;
      tx_start_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      shift_r       <= shift_s;
      cnt_r         <= cnt_s;
      addr_r        <= addr_s;
      scalar_mode_r <= scalar_mode_s;
      tx_data_r     <= tx_data_s;
      tx_start_r    <= (state_s == SEND);
      busy_r        <= (state_s != IDLE) && (state_s != DONE);
      done_r        <= (state_s == DONE);
    end
  end

  assign bram_rd_addr = addr_r;
  assign tx_data      = tx_data_r;
  assign tx_start     = tx_start_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_output_interface.sv
// Randomized bench for output_interface: a BRAM model, a UART busy model and a
// byte-queue reference built from the transfer rules check every transmitted byte.
module tb_output_interface;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [23:0] scalar_in = 24'd0;
  logic [9:0]  bram_rd_addr;
  logic [9:0]  bram_rd_dout = 10'd0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        busy;
  logic        done;

  output_interface #(.N_ELEM(N), .ADDR_W(10), .DATA_W(10), .RES_W(24)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .scalar_in(scalar_in),
    .bram_rd_addr(bram_rd_addr), .bram_rd_dout(bram_rd_dout), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [9:0] mem [0:N-1];
  always @(posedge clk) bram_rd_dout <= mem[bram_rd_addr[1:0]];

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  int tx_cnt = 0;
  int done_cnt = 0;
  bit uart_en = 1'b0;
  bit arm = 1'b0;
  int busy_cnt = 0;
  int hmin = 1;
  int hmax = 50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor plus UART model: tx_busy rises the cycle after tx_start and stays high hold cycles.
  initial forever begin
    @(posedge clk);
    #1;
    if (tx_start) begin
      tx_cnt++;
      check_eq("tx_while_busy", tx_busy, 0);
      check_eq("busy_with_tx", busy, 1);
      check_eq("byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("tx_data", tx_data, exp_q.pop_front());
    end
    if (done) done_cnt++;
    if (busy) check_eq("addr_range", bram_rd_addr < N, 1);
    if (uart_en) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (arm) begin
        tx_busy  = 1'b1;
        busy_cnt = $urandom_range(hmax, hmin);
        arm      = 1'b0;
      end
      if (tx_start) arm = 1'b1;
    end
  end

  // Drives an accepted start and queues the bytes the transfer rules predict.
  task automatic start_xfer(input bit m, input logic [23:0] s);
    int v;
    start = 1'b1;
    mode = m;
    scalar_in = s;
    if (m) begin
      v = int'(s);
      for (int b = 0; b < 3; b++) begin
        exp_q.push_back(8'(v % 256));
        v = v / 256;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        v = int'(mem[i]);
        exp_q.push_back(8'(v % 256));
        exp_q.push_back(8'(v / 256));
      end
    end
    cyc(1);
    start = 1'b0;
    mode = 1'($urandom);
    scalar_in = 24'($urandom);
    check_eq("busy_cycle1", busy, 1);
    check_eq("tx_start_cycle1", tx_start, m);
    if (!m) begin
      check_eq("addr_cycle1", bram_rd_addr, 0);
      cyc(2);
      check_eq("tx_start_cycle3", tx_start, 1);
    end
  endtask

  // Waits for done; poke drives a start during the DONE cycle, which must be ignored.
  task automatic wait_done(input int budget, input bit poke);
    int k = 0;
    while (!done && k < budget) begin
      cyc(1);
      k++;
    end
    check_eq("done_seen", done, 1);
    check_eq("busy_at_done", busy, 0);
    check_eq("exp_drained", exp_q.size(), 0);
    if (poke && done) begin
      start = 1'b1;
      mode = 1'($urandom);
      cyc(1);
      start = 1'b0;
      cyc(1);
      check_eq("start_in_done_ignored", busy, 0);
    end
  endtask

  task automatic run_xfer(input bit m, input logic [23:0] s);
    int d0 = done_cnt;
    start_xfer(m, s);
    wait_done(3000, 1'b0);
    cyc(3);
    check_eq("done_once", done_cnt, d0 + 1);
    check_eq("busy_after", busy, 0);
  endtask

  initial begin
    int b;
    int d0;
    mem[0] = 10'h3FF; mem[1] = 10'h001; mem[2] = 10'h200; mem[3] = 10'h155;
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); mode = 1'($urandom);
      scalar_in = 24'($urandom); tx_busy = 1'($urandom);
      cyc(1);
      check_eq("rst_tx_start", tx_start, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_tx_data", tx_data, 0);
      check_eq("rst_addr", bram_rd_addr, 0);
    end
    start = 1'b0; tx_busy = 1'b0; reset = 1'b1; uart_en = 1'b1;
    cyc(2);
    check_eq("idle_after_rst", busy, 0);

    hmin = 10; hmax = 10;
    run_xfer(1'b1, 24'hABCDEF);
    hmin = 1; hmax = 50;
    run_xfer(1'b0, 24'd0);

    // Random scalars and vectors with varied UART pacing
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) mem[i] = 10'($urandom);
      if (t % 2 == 1) hmax = 3; else hmax = 50;
      run_xfer(1'($urandom), 24'($urandom));
    end
    hmax = 50;

    // start while a vector transfer is running, and again in the DONE cycle
    d0 = done_cnt;
    start_xfer(1'b0, 24'd0);
    cyc(5);
    start = 1'b1; mode = 1'b1; scalar_in = 24'($urandom);
    cyc(1);
    start = 1'b0;
    wait_done(3000, 1'b1);
    cyc(2);
    check_eq("done_once_poke", done_cnt, d0 + 1);

    // start in the cycle right after DONE is accepted
    hmax = 4;
    start_xfer(1'b1, 24'h123456);
    wait_done(3000, 1'b0);
    cyc(1);
    run_xfer(1'b1, 24'h00FF01);

    // Mid-transfer reset after the third byte
    hmax = 20;
    b = tx_cnt;
    d0 = done_cnt;
    start_xfer(1'b0, 24'd0);
    for (int k = 0; k < 500 && tx_cnt < b + 3; k++) cyc(1);
    check_eq("third_byte_seen", tx_cnt, b + 3);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    exp_q.delete();
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_addr", bram_rd_addr, 0);
    check_eq("midrst_tx_start", tx_start, 0);
    b = tx_cnt;
    cyc(40);
    check_eq("no_tx_after_rst", tx_cnt, b);
    check_eq("no_done_after_rst", done_cnt, d0);
    run_xfer(1'b0, 24'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/output_interface.md
# output_interface

Transmit-side counterpart of the UART input interface. On a start request it serializes either one scalar result register or a complete vector read from a BRAM port into a stream of bytes for the UART transmitter. It sits between the processing core and the UART TX block. It drives the byte-wide `tx_start`/`tx_data` handshake and paces itself on `tx_busy`.

## Interface
- `N_ELEM`, 1024: number of vector elements sent in vector mode (≥1).
- `ADDR_W`, 10: BRAM read address width; 2^ADDR_W ≥ N_ELEM.
- `DATA_W`, 10: BRAM element width, legal range 9..16; always sent as 2 bytes.
- `RES_W`, 24: scalar result width, legal range 17..24; always sent as 3 bytes.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `mode`  in  1  sampled with `start`: 0 = vector dump, 1 = scalar.
- `scalar_in`  in  RES_W  scalar result, captured on accepted `start`.
- `bram_rd_addr`  out  ADDR_W  BRAM read address.
- `bram_rd_dout`  in  DATA_W  BRAM read data, 1-cycle read latency.
- `tx_data`  out  8  byte to transmit; stable from `tx_start` until the next `tx_start`.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_busy`  in  1  UART TX busy; must go high no later than 1 cycle after `tx_start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the last byte's completion.
- `done`  out  1  one-cycle pulse when the transfer is complete.

## Operation
- States: IDLE, FETCH, LATCH, SEND, HOLD, WAIT_TX, DONE.
- IDLE, `start`=1, `mode`=1: capture `scalar_in` into the shift register, set the byte count to 3, then go to SEND.
- IDLE, `start`=1, `mode`=0: set the element index to 0, drive `bram_rd_addr`=0, then go to FETCH.
- FETCH: address is stable; go to LATCH.
- LATCH: capture `bram_rd_dout`, zero-extended to 16 bits, and set the byte count to 2; go to SEND.
- SEND: `tx_start`=1 and `tx_data` = shift register [7:0]; go to HOLD.
- HOLD: ignore `tx_busy` for this cycle (covers the UART start latency); shift the register right by 8; go to WAIT_TX.
- WAIT_TX, `tx_busy`=1: stay.
- WAIT_TX, `tx_busy`=0, bytes remaining: go to SEND.
- WAIT_TX, `tx_busy`=0, element done and index < N_ELEM−1: increment index and `bram_rd_addr`, then go to FETCH.
- WAIT_TX, otherwise: go to DONE.
- DONE: `done`=1 for one cycle; go to IDLE.
- Byte order is little-endian: LSB first. Element upper bits beyond DATA_W are sent as 0. Scalar bits beyond RES_W are sent as 0.
- `start` is ignored in every state other than IDLE, including DONE. `mode` and `scalar_in` changes after capture have no effect.
- Totals per transfer: exactly 3 `tx_start` pulses in scalar mode, exactly 2·N_ELEM in vector mode.
- Reset (`reset`=0 at a clock edge), from any state including mid-transfer: go to IDLE and clear all counters. No further `tx_start` is issued. The next transfer restarts from address 0.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `bram_rd_addr`=0, `busy`=0, `done`=0, state IDLE.
- Accepted `start` at cycle 0 raises `busy` at cycle 1.
- Scalar mode: first `tx_start` at cycle 1.
- Vector mode: `bram_rd_addr`=0 valid at cycle 1 (FETCH), data captured at cycle 2 (LATCH), first `tx_start` at cycle 3.
- Consecutive `tx_start` pulses are at least 3 cycles apart: SEND, HOLD, then ≥1 WAIT_TX cycle.
- Between elements, the next address is issued the cycle after `tx_busy`=0 is seen. Its first byte's `tx_start` follows 3 cycles later.
- `busy` falls in the DONE cycle, concurrent with `done`=1. A `start` in the cycle after DONE is accepted.

## Test plan
- Reset: hold `reset`=0 for 4 cycles with random inputs → all outputs at their reset values and no `tx_start`.
- Scalar: `scalar_in`=24'hABCDEF, `mode`=1, UART model holds `tx_busy` high for 10 cycles per byte → bytes EF, CD, AB, then one `done` pulse; `busy` low afterwards.
- Vector: N_ELEM=4, BRAM = {10'h3FF, 10'h001, 10'h200, 10'h155} → bytes FF 03 01 00 00 02 55 01; `bram_rd_addr` steps 0→3; `done` pulses once.
- Pacing: vary `tx_busy` hold between 1 and 50 cycles, with `tx_busy` rising one cycle after `tx_start` → no `tx_start` while `tx_busy`=1 and no lost or duplicated bytes.
- Start while busy: pulse `start` with `mode` toggled during a vector transfer and in the DONE cycle → ignored; byte stream unchanged.
- Mid-transfer reset: assert `reset`=0 after the 3rd byte of a vector transfer → IDLE next cycle with no more `tx_start`; a new `start` resends from address 0.
